joint_histogram_scheduler: RTL

- Sequences the joint-histogram bin memory through four phases for each frame: clear, count, drain, and ordered read-out.
- The bin address is the 9-bit concatenation {ci, ni, rd}, giving 512 bins.
- Sits between the feature pipeline, which supplies (ci, ni, rd) samples, and a single-port bin RAM with an external increment unit.
- Streams the final counts to the output stage over a valid/ready handshake.

---
 rtl/joint_histogram_scheduler.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/joint_histogram_scheduler.sv
// Frame scheduler for the joint-histogram bin RAM: clears every bin, counts
// feature samples, lets the increment unit drain, then streams bins in address order.
module joint_histogram_scheduler #(
  parameter int ADDR_W  = 9,
  parameter int CNT_W   = 16,
  parameter int RMW_LAT = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  input  logic              done_i,
  input  logic              ci_i,
  input  logic [3:0]        ni_i,
  input  logic [3:0]        rd_i,
  input  logic              progress_done_i,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic              mem_clr_o,
  output logic              mem_inc_o,
  output logic              mem_re_o,
  input  logic [CNT_W-1:0]  mem_rdata_i,
  output logic [CNT_W-1:0]  cinird_o,
  output logic              valid_o,
  input  logic              ready_i,
  output logic              busy_o,
  output logic              finish_o,
  output logic              drop_err_o
);

  typedef enum logic [2:0] {
    S_IDLE, S_CLEAR, S_COUNT, S_DRAIN, S_READ, S_FINISH
  } state_t;

  localparam int DW = (RMW_LAT > 1) ? $clog2(RMW_LAT) : 1;

  state_t state_q, state_n;

  logic [ADDR_W-1:0] ptr_q;
  logic [ADDR_W:0]   rptr_q;
  logic [ADDR_W-1:0] out_cnt_q;
  logic [DW-1:0]     drain_cnt_q;

  logic              clr_q, inc_q, finish_q, busy_q, drop_q;
  logic [ADDR_W-1:0] addr_q;
  logic              clr_n, inc_n, finish_n, busy_n, drop_n;
  logic [ADDR_W-1:0] addr_n;

  logic [CNT_W-1:0]  skid_q [2];
  logic [1:0]        occ_q;
  logic              pend_q;

  logic              pop, last_clear, drain_done, last_word, rd_issue;
  logic [1:0]        credit_used;

  assign pop         = (occ_q != 2'd0) && ready_i;
  assign last_clear  = &ptr_q;
  assign drain_done  = !inc_q && (drain_cnt_q == DW'(RMW_LAT - 1));
  assign last_word   = pop && (&out_cnt_q);

  // Reads are issued against this cycle's handshake so a 2-entry buffer still
  // sustains one word per cycle: data in flight plus words left after the pop.
  assign credit_used = occ_q - 2'(pop) + 2'(pend_q);
  assign rd_issue    = (state_q == S_READ) && !rptr_q[ADDR_W] && (credit_used < 2'd2);

  always_comb begin
    state_n = state_q;
    unique case (state_q)
      S_IDLE:   if (start_i)         state_n = S_CLEAR;
      S_CLEAR:  if (last_clear)      state_n = S_COUNT;
      S_COUNT:  if (progress_done_i) state_n = S_DRAIN;
      S_DRAIN:  if (drain_done)      state_n = S_READ;
      S_READ:   if (last_word)       state_n = S_FINISH;
      S_FINISH:                      state_n = S_IDLE;
      default:                       state_n = S_IDLE;
    endcase
  end

  // NOTE: every signal assigned in always_comb gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    clr_n    = (state_n == S_CLEAR);
    inc_n    = (state_q == S_COUNT) && done_i;
    addr_n   = '0;
    if (inc_n) begin
      addr_n = {ci_i, ni_i, rd_i};
    end else if ((state_q == S_CLEAR) && !last_clear) begin
      addr_n = ptr_q + ADDR_W'(1);
    end
    finish_n = (state_n == S_FINISH);
    busy_n   = (state_n != S_IDLE);
    drop_n   = (((state_q == S_IDLE) && start_i) ? 1'b0 : drop_q)
             | (done_i && (state_q != S_COUNT));
  end

  // NOTE: clocked state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      clr_q    <= 1'b0;
      inc_q    <= 1'b0;
      addr_q   <= '0;
      finish_q <= 1'b0;
      busy_q   <= 1'b0;
      drop_q   <= 1'b0;
    end else begin
      state_q  <= state_n;
      clr_q    <= clr_n;
      inc_q    <= inc_n;
      addr_q   <= addr_n;
      finish_q <= finish_n;
      busy_q   <= busy_n;
      drop_q   <= drop_n;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr_q       <= '0;
      rptr_q      <= '0;
      out_cnt_q   <= '0;
      drain_cnt_q <= '0;
      pend_q      <= 1'b0;
    end else begin
      ptr_q <= (state_q == S_CLEAR) ? ptr_q + ADDR_W'(1) : '0;

      if (state_q != S_READ)  rptr_q <= '0;
      else if (rd_issue)      rptr_q <= rptr_q + (ADDR_W+1)'(1);

      if (state_q != S_READ)  out_cnt_q <= '0;
      else if (pop)           out_cnt_q <= out_cnt_q + ADDR_W'(1);

      // The idle count restarts while the final increment is still on the bus.
      if ((state_q != S_DRAIN) || inc_q) drain_cnt_q <= '0;
      else if (!drain_done)              drain_cnt_q <= drain_cnt_q + DW'(1);

      pend_q <= rd_issue;
    end
  end

  // NOTE: the skid entries are reset because entry 0 is the visible cinird_o, which must read 0 out of reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      skid_q[0] <= '0;
      skid_q[1] <= '0;
      occ_q     <= 2'd0;
    end else begin
      unique case ({pop, pend_q})
        2'b11: begin
          if (occ_q == 2'd2) begin
            skid_q[0] <= skid_q[1];
            skid_q[1] <= mem_rdata_i;
          end else begin
            skid_q[0] <= mem_rdata_i;
          end
        end
        2'b10: begin
          skid_q[0] <= skid_q[1];
          occ_q     <= occ_q - 2'd1;
        end
        2'b01: begin
          if (occ_q == 2'd0) skid_q[0] <= mem_rdata_i;
          else               skid_q[1] <= mem_rdata_i;
          occ_q <= occ_q + 2'd1;
        end
        default: ;
      endcase
    end
  end

  assign mem_clr_o  = clr_q;
  assign mem_inc_o  = inc_q;
  assign mem_re_o   = rd_issue;
  assign mem_addr_o = rd_issue ? rptr_q[ADDR_W-1:0] : addr_q;
  assign cinird_o   = skid_q[0];
  assign valid_o    = (occ_q != 2'd0);
  assign busy_o     = busy_q;
  assign finish_o   = finish_q;
  assign drop_err_o = drop_q;

endmodule
